// File: rtl/prescaled_timer.sv
// Prescaled up/down timer. The clock is divided by presc+1 (counting only
// enabled clocks); each prescaled step moves the N-bit count and raises the
// one-cycle tick that enables a downstream counter. Compare-match and wrap
// pulses accompany each step, and one-shot mode parks the timer in DONE on match.
module prescaled_timer #(
    parameter int N = 4,
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         res_n,
    input  logic         en,
    input  logic         start,
    input  logic         mode,
    input  logic         count_up,
    input  logic [P-1:0] presc,
    input  logic         load,
    input  logic [N-1:0] set,
    input  logic [N-1:0] cmp,
    output logic         tick,
    output logic [N-1:0] count,
    output logic         match,
    output logic         wrap,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] CNT_ONE = N'(1);
    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [P-1:0] PSC_ONE = P'(1);

    state_t       state_q, state_d;
    logic [P-1:0] psc_q, psc_d;
    logic [N-1:0] count_q, count_d;
    logic         tick_q, tick_d;
    logic         match_q, match_d;
    logic         wrap_q, wrap_d;
    logic         busy_q, busy_d;
    logic [N-1:0] stepped;

    // Next-state: load beats a step; steps only happen in RUN with en high.
    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        match_d = 1'b0;
        wrap_d  = 1'b0;
        stepped = count_up ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
        if (load) begin
            count_d = set;
            psc_d   = '0;
            if (state_q != RUN && start) state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        // >= lets a lowered presc end the current period at once
                        if (psc_q >= presc) begin
                            psc_d   = '0;
                            tick_d  = 1'b1;
                            count_d = stepped;
                            wrap_d  = count_up ? (count_q == CNT_MAX) : (count_q == '0);
                            match_d = (stepped == cmp);
                            if (match_d && mode) state_d = DONE;
                        end else begin
                            psc_d = psc_q + PSC_ONE;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_d = RUN;
                        psc_d   = '0;
                    end
                end
            endcase
        end
        busy_d = (state_d == RUN);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= IDLE;
            psc_q   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            match_q <= 1'b0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            match_q <= match_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
        end
    end

    assign tick  = tick_q;
    assign count = count_q;
    assign match = match_q;
    assign wrap  = wrap_q;
    assign busy  = busy_q;

endmodule
